stream_join_buffered: RTL and testbench
=======================================

# stream_join_buffered

Multi-input valid/ready join stage. It collects one word from each of SIGNALS independent input streams, then emits them as a single concatenated word on one output stream. It sits downstream of the per-consumer branches fed by the fifo splitter, where parallel results (e.g. per-neuron products or deltas) must be recombined before the next layer stage. Each input has its own one-entry holding register, so inputs may arrive in any order and on different cycles.

## Interface
- DATA_WIDTH, 32, width of one input word
- SIGNALS, 4, number of input streams joined
- COUNT_WIDTH, 16, width of join_count (only used with STREAM_JOIN_COUNT_EN)

- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- data_in  input  DATA_WIDTH*SIGNALS  input i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- data_in_valid  input  SIGNALS  per-input valid
- data_in_ready  output  SIGNALS  per-input ready
- data_out  output  DATA_WIDTH*SIGNALS  joined word, lane i = word captured from input i
- data_out_valid  output  1  output word valid
- data_out_ready  input  1  downstream ready
- join_count  output  COUNT_WIDTH  completed output transfers (only with STREAM_JOIN_COUNT_EN)

## Operation
- State: hold_data[i] (DATA_WIDTH), held[i] (1 bit) per input; out_data (DATA_WIDTH*SIGNALS), out_valid (1 bit).
- all_held = &held.
- out_free = ~out_valid | data_out_ready.
- fire = all_held & out_free.
- data_in_ready[i] = ~held[i] | fire (combinational path from data_out_ready permitted).
- Input accept: data_in_valid[i] & data_in_ready[i] at an edge. At that edge hold_data[i] <= data_in lane i and held[i] <= 1.
- Fire at an edge:
  - out_data <= concatenation of hold_data, out_valid <= 1.
  - Each held[i] <= 0, unless input i is accepted in the same cycle, in which case held[i] stays 1 with the new data.
- Output handshake: if out_valid & data_out_ready and no fire, out_valid <= 0.
- Output held stable while out_valid & ~data_out_ready. Inputs already held wait; unheld inputs still accept.
- A held lane never accepts a second word until a fire. An input valid while held and not firing is back-pressured (ready=0).
- Lane order in data_out is fixed by input index, independent of arrival order.

## Timing
- Reset values: held=0, out_valid=0, out_data=0, hold_data=0, data_in_ready=all ones, data_out_valid=0, data_out=0, join_count=0.
- Latency: the last missing input accepted at edge k gives fire at edge k+1 (if out_free) and data_out_valid=1 after edge k+1.
- Throughput: one join per cycle sustained when all inputs are valid every cycle and data_out_ready=1. This works because ready reasserts during fire.
- Simultaneous output drain and fire at the same edge: out_data is replaced and out_valid stays 1, with no bubble.
- Reset mid-operation discards held words and any pending output next edge. No output transfer completes on the reset edge.
- data_out_valid must not depend combinationally on data_in_valid. It is registered only.

## Configuration
- STREAM_JOIN_COUNT_EN defined:
  - join_count port exists.
  - It increments by 1 on each edge where out_valid & data_out_ready.
  - It wraps from 2^COUNT_WIDTH-1 to 0.
  - It is cleared by rst.
- Not defined: port and counter absent. Datapath behaviour is identical.

## Test plan
All scenarios use DATA_WIDTH=8, SIGNALS=3.
- Reset: assert rst 2 cycles with inputs valid -> data_out_valid=0, data_in_ready=3'b111, data_out=0 after release.
- Staggered arrival:
  - Stimulus: lane2=0x33 at cycle 0, lane0=0x11 at cycle 2, lane1=0x22 at cycle 5; data_out_ready=1.
  - Response: data_out=0x332211, valid exactly one cycle, starting the cycle after lane1's accept edge.
  - Also check: data_in_ready[2]=0 during cycles 1-5.
- Back-pressure:
  - Stimulus: data_out_ready=0 for 10 cycles after the first join; new words 0xA1/0xA2/0xA3 are offered.
  - Response: data_out holds its first value, all held lanes go ready=0, no data lost.
  - After ready=1: next output is 0xA3A2A1.
- Streaming: all inputs valid every cycle with incrementing values for 20 cycles, ready=1 -> 20 outputs (after pipeline fill), in order, no bubbles.
- Reset mid-operation: hold lanes 0,1 and pulse rst -> after reset, a single lane2 word produces no output until lanes 0 and 1 arrive again.
- With STREAM_JOIN_COUNT_EN and COUNT_WIDTH=4: 17 output transfers -> join_count=1 (wrapped).

Source files
------------

// File: rtl/stream_join_buffered_if.sv
// Valid/ready bundle for the buffered N-way stream join: per-lane input streams plus one joined output.
interface stream_join_buffered_if #(
  parameter int DATA_WIDTH = 32,
  parameter int SIGNALS    = 4
);
  logic [DATA_WIDTH*SIGNALS-1:0] data_in;
  logic [SIGNALS-1:0]            data_in_valid;
  logic [SIGNALS-1:0]            data_in_ready;
  logic [DATA_WIDTH*SIGNALS-1:0] data_out;
  logic                          data_out_valid;
  logic                          data_out_ready;

  modport master (
    output data_in, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_valid
  );

  modport slave (
    input  data_in, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_valid
  );
endinterface

// File: rtl/stream_join_buffered.sv
// Joins one word from each of SIGNALS input streams into a single registered output word.
// Optional transfer counter enabled by defining STREAM_JOIN_COUNT_EN.
module stream_join_buffered #(
  parameter int DATA_WIDTH = 32,
  parameter int SIGNALS    = 4
`ifdef STREAM_JOIN_COUNT_EN
  , parameter int COUNT_WIDTH = 16
`endif
) (
  input logic                       clk,
  input logic                       rst,
  stream_join_buffered_if.slave     bus
`ifdef STREAM_JOIN_COUNT_EN
  , output logic [COUNT_WIDTH-1:0]  o_join_count
`endif
);

  logic [DATA_WIDTH-1:0]         r_hold_data [SIGNALS];
  logic [SIGNALS-1:0]            r_held;
  logic [DATA_WIDTH*SIGNALS-1:0] r_out_data;
  logic                          r_out_valid;

  logic                          w_all_held;
  logic                          w_out_free;
  logic                          w_fire;
  logic [SIGNALS-1:0]            w_in_ready;
  logic [SIGNALS-1:0]            w_accept;
  logic [DATA_WIDTH*SIGNALS-1:0] w_joined;

  assign w_all_held = &r_held;
  assign w_out_free = ~r_out_valid | bus.data_out_ready;
  assign w_fire     = w_all_held & w_out_free;
  // Ready reasserts during fire so a full set of inputs can stream one join per cycle.
  assign w_in_ready = ~r_held | {SIGNALS{w_fire}};
  assign w_accept   = bus.data_in_valid & w_in_ready;

  always_comb begin
    w_joined = '0;
    for (int i = 0; i < SIGNALS; i++) begin
      w_joined[i*DATA_WIDTH +: DATA_WIDTH] = r_hold_data[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_held      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      for (int i = 0; i < SIGNALS; i++) begin
        r_hold_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SIGNALS; i++) begin
        if (w_accept[i]) begin
          r_hold_data[i] <= bus.data_in[i*DATA_WIDTH +: DATA_WIDTH];
          r_held[i]      <= 1'b1;
        end else if (w_fire) begin
          r_held[i] <= 1'b0;
        end
      end
      if (w_fire) begin
        r_out_data  <= w_joined;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && bus.data_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.data_in_ready  = w_in_ready;
  assign bus.data_out       = r_out_data;
  assign bus.data_out_valid = r_out_valid;

`ifdef STREAM_JOIN_COUNT_EN
  logic [COUNT_WIDTH-1:0] r_join_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_join_count <= '0;
    end else if (r_out_valid && bus.data_out_ready) begin
      r_join_count <= r_join_count + COUNT_WIDTH'(1);
    end
  end

  assign o_join_count = r_join_count;
`endif

endmodule

// File: tb/tb_stream_join_buffered.sv
// Directed bench for stream_join_buffered with DATA_WIDTH=8, SIGNALS=3 (counter checks when STREAM_JOIN_COUNT_EN is defined).
module tb_stream_join_buffered;
  localparam int DW = 8;
  localparam int NS = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  stream_join_buffered_if #(.DATA_WIDTH(DW), .SIGNALS(NS)) bus ();

`ifdef STREAM_JOIN_COUNT_EN
  logic [3:0] join_count;
  stream_join_buffered #(.DATA_WIDTH(DW), .SIGNALS(NS), .COUNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .o_join_count(join_count));
`else
  stream_join_buffered #(.DATA_WIDTH(DW), .SIGNALS(NS)) dut (
    .clk(clk), .rst(rst), .bus(bus));
`endif

  typedef struct {
    logic        rst;
    logic [2:0]  vld;
    logic [23:0] din;
    logic        ordy;
    logic [2:0]  rdy;
    logic        ovld;
    logic [23:0] odata;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [2:0] v, logic [23:0] d, logic o,
                              logic [2:0] er, logic ev, logic [23:0] ed);
    vec_t t;
    t.rst = r; t.vld = v; t.din = d; t.ordy = o;
    t.rdy = er; t.ovld = ev; t.odata = ed;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] stream_word(input int n);
    logic [7:0] b0, b1, b2;
    b0 = 8'(n * 4);
    b1 = 8'(n * 4 + 1);
    b2 = 8'(n * 4 + 2);
    return {b2, b1, b0};
  endfunction

  initial begin
    logic [23:0] expq[$];
    logic [23:0] e;
    int outs;

    // Staggered arrival, back-pressure with a simultaneous drain+fire, then reset mid-operation.
    tbl.push_back(mk(0, 3'b100, 24'h330000, 1, 3'b111, 0, 24'h000000));
    tbl.push_back(mk(0, 3'b000, 24'h000000, 1, 3'b011, 0, 24'h000000));
    tbl.push_back(mk(0, 3'b001, 24'h000011, 1, 3'b011, 0, 24'h000000));
    tbl.push_back(mk(0, 3'b000, 24'h000000, 1, 3'b010, 0, 24'h000000));
    tbl.push_back(mk(0, 3'b000, 24'h000000, 1, 3'b010, 0, 24'h000000));
    tbl.push_back(mk(0, 3'b010, 24'h002200, 1, 3'b010, 0, 24'h000000));
    tbl.push_back(mk(0, 3'b000, 24'h000000, 1, 3'b111, 0, 24'h000000));
    tbl.push_back(mk(0, 3'b000, 24'h000000, 1, 3'b111, 1, 24'h332211));
    tbl.push_back(mk(0, 3'b000, 24'h000000, 1, 3'b111, 0, 24'h332211));
    tbl.push_back(mk(0, 3'b111, 24'h030201, 0, 3'b111, 0, 24'h332211));
    tbl.push_back(mk(0, 3'b111, 24'hA3A2A1, 0, 3'b111, 0, 24'h332211));
    for (int k = 0; k < 9; k++)
      tbl.push_back(mk(0, 3'b111, 24'hC3C2C1, 0, 3'b000, 1, 24'h030201));
    tbl.push_back(mk(0, 3'b000, 24'h000000, 1, 3'b111, 1, 24'h030201));
    tbl.push_back(mk(0, 3'b000, 24'h000000, 1, 3'b111, 1, 24'hA3A2A1));
    tbl.push_back(mk(0, 3'b000, 24'h000000, 1, 3'b111, 0, 24'hA3A2A1));
    tbl.push_back(mk(0, 3'b011, 24'h005544, 1, 3'b111, 0, 24'hA3A2A1));
    tbl.push_back(mk(1, 3'b000, 24'h000000, 1, 3'b100, 0, 24'hA3A2A1));
    tbl.push_back(mk(0, 3'b100, 24'h660000, 1, 3'b111, 0, 24'h000000));
    tbl.push_back(mk(0, 3'b000, 24'h000000, 1, 3'b011, 0, 24'h000000));
    tbl.push_back(mk(0, 3'b000, 24'h000000, 1, 3'b011, 0, 24'h000000));
    tbl.push_back(mk(0, 3'b011, 24'h008877, 1, 3'b011, 0, 24'h000000));
    tbl.push_back(mk(0, 3'b000, 24'h000000, 1, 3'b111, 0, 24'h000000));
    tbl.push_back(mk(0, 3'b000, 24'h000000, 1, 3'b111, 1, 24'h668877));
    tbl.push_back(mk(0, 3'b000, 24'h000000, 1, 3'b111, 0, 24'h668877));

    // Reset held for two edges with every input offering data.
    rst = 1'b1;
    bus.data_in = 24'hEEDDCC;
    bus.data_in_valid = 3'b111;
    bus.data_out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.data_in_valid = 3'b000;
    bus.data_in = '0;
    #1;
    chk("reset_out_valid", 32'(bus.data_out_valid), 32'(1'b0));
    chk("reset_in_ready", 32'(bus.data_in_ready), 32'(3'b111));
    chk("reset_out_data", 32'(bus.data_out), 32'(24'h0));

    foreach (tbl[n]) begin
      @(negedge clk);
      rst = tbl[n].rst;
      bus.data_in_valid = tbl[n].vld;
      bus.data_in = tbl[n].din;
      bus.data_out_ready = tbl[n].ordy;
      #1;
      chk($sformatf("vec%0d_in_ready", n), 32'(bus.data_in_ready), 32'(tbl[n].rdy));
      chk($sformatf("vec%0d_out_valid", n), 32'(bus.data_out_valid), 32'(tbl[n].ovld));
      chk($sformatf("vec%0d_out_data", n), 32'(bus.data_out), 32'(tbl[n].odata));
    end

    // Streaming: 20 full sets back-to-back, expect 20 in-order outputs with no bubbles.
    outs = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      @(negedge clk);
      rst = 1'b0;
      bus.data_out_ready = 1'b1;
      if (cyc < 20) begin
        bus.data_in_valid = 3'b111;
        bus.data_in = stream_word(cyc);
      end else begin
        bus.data_in_valid = 3'b000;
        bus.data_in = '0;
      end
      #1;
      if (cyc < 20) chk($sformatf("stream%0d_in_ready", cyc), 32'(bus.data_in_ready), 32'(3'b111));
      chk($sformatf("stream%0d_out_valid", cyc), 32'(bus.data_out_valid),
          32'((cyc >= 2 && cyc < 22) ? 1'b1 : 1'b0));
      if (bus.data_out_valid === 1'b1) begin
        if (expq.size() == 0) begin
          chk($sformatf("stream%0d_unexpected_output", cyc), 32'(bus.data_out), 32'hFFFFFFFF);
        end else begin
          e = expq.pop_front();
          chk($sformatf("stream_out%0d_data", outs), 32'(bus.data_out), 32'(e));
        end
        outs++;
      end
      if (cyc < 20) expq.push_back(stream_word(cyc));
    end
    chk("stream_output_count", 32'(outs), 32'd20);

`ifdef STREAM_JOIN_COUNT_EN
    // 17 transfers on a 4-bit counter wrap it to 1.
    @(negedge clk);
    rst = 1'b1;
    bus.data_in_valid = 3'b000;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("count_after_reset", 32'(join_count), 32'd0);
    outs = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (outs == 17) begin
        bus.data_in_valid = 3'b000;
        bus.data_out_ready = 1'b0;
        break;
      end
      bus.data_in_valid = 3'b111;
      bus.data_in = stream_word(cyc);
      bus.data_out_ready = 1'b1;
      #1;
      if (bus.data_out_valid === 1'b1) outs++;
    end
    chk("count_transfers_seen", 32'(outs), 32'd17);
    @(negedge clk);
    chk("count_wrapped", 32'(join_count), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
